// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and default sizes for the reaction-game controller.
//   state_t      - controller state encoding, also exported on the debug port
//   *_DEF        - default parameter values for reaction_ctrl
package reaction_pkg;

   localparam int N_LEDS_DEF  = 10;
   localparam int DELAY_W_DEF = 8;
   localparam int TIME_W_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_DELAY     = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

endpackage

// File: rtl/press_detect.sv
// press_detect: one-cycle press strobe on the falling edge of an active-low,
// already-synchronised button. The history register resets to 1 (released),
// so a button held through reset does not produce a phantom press.
//   clk, rst_n - clock, asynchronous active-low reset
//   btn_n      - button level, active low
//   press      - high for the single cycle in which btn_n is first seen low
module press_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   logic btn_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_prev <= 1'b1;
      else        btn_prev <= btn_n;
   end

   assign press = btn_prev & ~btn_n;

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-game controller. Runs a thermometer LED countdown on
// the tick enable, holds off for a random number of ticks taken from the board
// LFSR, then counts ticks until the player presses. Early presses are flagged
// as a false start; a run that reaches the counter limit reports all-ones with
// timeout set.
//   clk, rst_n    - clock, asynchronous active-low reset
//   tick          - one-clk enable strobe from the tick divider
//   trigger_n     - player button, active low, synchronous to clk
//   rand_delay    - current LFSR value, sampled when the countdown finishes
//   lfsr_en       - lets the LFSR free-run (high only during the countdown)
//   ledr          - countdown lights, filled from bit 0 upwards
//   reaction_time - last result in ticks, held until the next result
//   result_valid  - one-clk pulse when reaction_time is written
//   false_start   - high while waiting for the acknowledging press after a fault
//   timeout       - set with a saturated result, cleared when a game starts
//   state_dbg     - current controller state (reaction_pkg::state_t encoding)
//
// Interface protocol: there is no valid/ready handshake here. tick and the
// press strobe are single-cycle events acted on in the cycle they are seen;
// result_valid is a single-cycle qualifier for reaction_time with no
// back-pressure, so a consumer must capture it in that cycle.
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter int N_LEDS  = N_LEDS_DEF,
   parameter int DELAY_W = DELAY_W_DEF,
   parameter int TIME_W  = TIME_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               trigger_n,
   input  logic [DELAY_W-1:0] rand_delay,
   output logic               lfsr_en,
   output logic [N_LEDS-1:0]  ledr,
   output logic [TIME_W-1:0]  reaction_time,
   output logic               result_valid,
   output logic               false_start,
   output logic               timeout,
   output logic [2:0]         state_dbg
);

   localparam logic [N_LEDS-1:0] LED_ALL  = '1;
   localparam logic [TIME_W-1:0] TIME_MAX = '1;
   // The tick that would take the counter to all-ones ends the run instead.
   localparam logic [TIME_W-1:0] TIME_LAST = TIME_MAX - TIME_W'(1);

   state_t             state;
   logic               press;
   logic [DELAY_W-1:0] delay_cnt;
   logic [TIME_W-1:0]  run_cnt;

   press_detect u_press_detect (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (trigger_n),
      .press (press)
   );

   assign state_dbg = state;

   // In every state the press branch is tested before the tick branch, so a
   // tick arriving together with a press is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         lfsr_en       <= 1'b0;
         ledr          <= '0;
         reaction_time <= '0;
         result_valid  <= 1'b0;
         false_start   <= 1'b0;
         timeout       <= 1'b0;
         delay_cnt     <= '0;
         run_cnt       <= '0;
      end else begin
         result_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (press) begin
                  state   <= ST_COUNTDOWN;
                  lfsr_en <= 1'b1;
                  ledr    <= '0;
                  timeout <= 1'b0;
               end
            end
            ST_COUNTDOWN: begin
               if (press) begin
                  state       <= ST_FAULT;
                  false_start <= 1'b1;
                  ledr        <= LED_ALL;
                  lfsr_en     <= 1'b0;
               end else if (tick) begin
                  // The top LED being lit means all are lit; this extra tick
                  // ends the countdown.
                  if (ledr[N_LEDS-1]) begin
                     state     <= ST_DELAY;
                     lfsr_en   <= 1'b0;
                     delay_cnt <= (rand_delay == '0) ? DELAY_W'(1) : rand_delay;
                  end else begin
                     ledr <= (ledr << 1) | N_LEDS'(1);
                  end
               end
            end
            ST_DELAY: begin
               if (press) begin
                  state       <= ST_FAULT;
                  false_start <= 1'b1;
                  lfsr_en     <= 1'b0;
               end else if (tick) begin
                  // Leaving on the tick that would reach zero gives exactly
                  // delay_cnt ticks in this state.
                  if (delay_cnt == DELAY_W'(1)) begin
                     state   <= ST_RUN;
                     ledr    <= '0;
                     run_cnt <= '0;
                  end else begin
                     delay_cnt <= delay_cnt - DELAY_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (press) begin
                  reaction_time <= run_cnt;
                  result_valid  <= 1'b1;
                  state         <= ST_IDLE;
               end else if (tick) begin
                  if (run_cnt == TIME_LAST) begin
                     reaction_time <= TIME_MAX;
                     timeout       <= 1'b1;
                     result_valid  <= 1'b1;
                     state         <= ST_IDLE;
                  end else begin
                     run_cnt <= run_cnt + TIME_W'(1);
                  end
               end
            end
            ST_FAULT: begin
               if (press) begin
                  state       <= ST_IDLE;
                  false_start <= 1'b0;
                  ledr        <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: self-checking bench for reaction_ctrl with N_LEDS=4,
// DELAY_W=8, TIME_W=8. Expected values come from the game rules: a round with
// k ticks before the press must report k, a run of 255 ticks reports 8'hFF.
module tb_reaction_ctrl;
   import reaction_pkg::*;

   localparam int NL = 4;
   localparam int DW = 8;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tick;
   logic          trigger_n;
   logic [DW-1:0] rand_delay;
   logic          lfsr_en;
   logic [NL-1:0] ledr;
   logic [TW-1:0] reaction_time;
   logic          result_valid;
   logic          false_start;
   logic          timeout;
   logic [2:0]    state_dbg;

   int            checks = 0;
   int            passes = 0;
   int            rd_force = -1;
   int            n_exp = 0;
   int            rv_seen = 0;
   logic          rv_prev = 1'b0;
   logic [TW-1:0] last_res = '0;
   logic [TW-1:0] exp_q[$];

   reaction_ctrl #(.N_LEDS(NL), .DELAY_W(DW), .TIME_W(TW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .trigger_n     (trigger_n),
      .rand_delay    (rand_delay),
      .lfsr_en       (lfsr_en),
      .ledr          (ledr),
      .reaction_time (reaction_time),
      .result_valid  (result_valid),
      .false_start   (false_start),
      .timeout       (timeout),
      .state_dbg     (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [TW-1:0] e;
      if (result_valid === 1'b1) begin
         rv_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected got %0d required no result", reaction_time);
         end else begin
            e = exp_q.pop_front();
            if (reaction_time !== e) $display("FAIL sb_result got %0d required %0d", reaction_time, e);
            else passes++;
         end
         checks++;
         if (rv_prev === 1'b1) $display("FAIL rv_width got 2+ cycles required 1");
         else passes++;
      end
      rv_prev = result_valid;
   end

   // ---------------- drivers ----------------
   // Inputs change at the falling edge; outputs are sampled at the next one.
   task automatic cyc(input logic t, input logic trg);
      tick       = t;
      trigger_n  = trg;
      rand_delay = (rd_force >= 0) ? DW'(rd_force) : DW'($urandom_range(0, 255));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tk();
      int g;
      g = $urandom_range(0, 2);
      repeat (g) cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
   endtask

   // Button goes low for one cycle; the next cyc call releases it.
   task automatic press(input logic t);
      cyc(t, 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int bad;
      rst_n = 1'b0; tick = 1'b0; trigger_n = 1'b1; rand_delay = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({lfsr_en, ledr, reaction_time, result_valid, false_start, timeout} !== '0)
         $display("FAIL reset_outputs got %b required 0",
                  {lfsr_en, ledr, reaction_time, result_valid, false_start, timeout});
      else passes++;
      rst_n = 1'b1;
      cyc(1'b0, 1'b1);
      checks++;
      if (state_dbg !== ST_IDLE) $display("FAIL reset_state got %0d required %0d", state_dbg, ST_IDLE);
      else passes++;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tk();
         if (ledr !== '0 || lfsr_en !== 1'b0 || result_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL idle_quiet got %0d active cycles required 0", bad);
      else passes++;
   endtask

   task automatic start_game();
      press(1'b0);
      checks++;
      if (lfsr_en !== 1'b1 || ledr !== '0 || timeout !== 1'b0 || false_start !== 1'b0)
         $display("FAIL start got lfsr_en=%b ledr=%b timeout=%b fs=%b required 1/0000/0/0",
                  lfsr_en, ledr, timeout, false_start);
      else passes++;
      checks++;
      if (reaction_time !== last_res) $display("FAIL start_hold got %0d required %0d", reaction_time, last_res);
      else passes++;
   endtask

   // Lights all LEDs and ends the countdown with rand_delay=rd on the final tick.
   task automatic countdown(input int rd);
      logic [NL-1:0] exp_led;
      for (int i = 1; i <= NL; i++) begin
         tk();
         exp_led = NL'((2 ** i) - 1);
         checks++;
         if (ledr !== exp_led || lfsr_en !== 1'b1)
            $display("FAIL countdown_led got %b/%b required %b/1", ledr, lfsr_en, exp_led);
         else passes++;
      end
      rd_force = rd;
      tk();
      rd_force = -1;
      checks++;
      if (ledr !== 4'b1111 || lfsr_en !== 1'b0)
         $display("FAIL enter_delay got %b/%b required 1111/0", ledr, lfsr_en);
      else passes++;
   endtask

   task automatic play_round(input int rd, input int k, input bit coinc);
      int dly;
      dly = (rd == 0) ? 1 : rd;
      start_game();
      countdown(rd);
      for (int i = 1; i < dly; i++) tk();
      checks++;
      if (ledr !== 4'b1111) $display("FAIL delay_hold got %b required 1111", ledr);
      else passes++;
      tk();
      checks++;
      if (ledr !== '0 || state_dbg !== ST_RUN)
         $display("FAIL enter_run got %b/%0d required 0000/%0d", ledr, state_dbg, ST_RUN);
      else passes++;
      if (k >= 255) begin
         repeat (254) tk();
         checks++;
         if (result_valid !== 1'b0 || timeout !== 1'b0)
            $display("FAIL early_timeout got rv=%b to=%b required 0/0", result_valid, timeout);
         else passes++;
         exp_q.push_back(8'hFF); n_exp++;
         tk();
         last_res = 8'hFF;
      end else begin
         repeat (k) tk();
         exp_q.push_back(TW'(k)); n_exp++;
         press(coinc);
         last_res = TW'(k);
      end
      checks++;
      if (result_valid !== 1'b1 || reaction_time !== last_res)
         $display("FAIL result got rv=%b time=%0d required 1/%0d", result_valid, reaction_time, last_res);
      else passes++;
      checks++;
      if (timeout !== (k >= 255)) $display("FAIL timeout_flag got %b required %b", timeout, k >= 255);
      else passes++;
      cyc(1'b0, 1'b1);
      checks++;
      if (result_valid !== 1'b0 || ledr !== '0 || lfsr_en !== 1'b0 || reaction_time !== last_res)
         $display("FAIL post_result got rv=%b ledr=%b time=%0d required 0/0000/%0d",
                  result_valid, ledr, reaction_time, last_res);
      else passes++;
   endtask

   task automatic test_false_start(input bit in_delay);
      start_game();
      if (in_delay) begin
         countdown(10);
         repeat (3) tk();
      end else begin
         repeat (2) tk();
         checks++;
         if (ledr !== 4'b0011) $display("FAIL fs_two_lit got %b required 0011", ledr);
         else passes++;
      end
      press(1'b0);
      checks++;
      if (false_start !== 1'b1 || ledr !== 4'b1111 || lfsr_en !== 1'b0 || result_valid !== 1'b0)
         $display("FAIL fs_enter got fs=%b ledr=%b lfsr=%b rv=%b required 1/1111/0/0",
                  false_start, ledr, lfsr_en, result_valid);
      else passes++;
      repeat (3) tk();
      checks++;
      if (false_start !== 1'b1 || ledr !== 4'b1111) $display("FAIL fs_hold got %b/%b required 1/1111", false_start, ledr);
      else passes++;
      press(1'b0);
      checks++;
      if (false_start !== 1'b0 || ledr !== '0 || lfsr_en !== 1'b0)
         $display("FAIL fs_clear got fs=%b ledr=%b lfsr=%b required 0/0000/0", false_start, ledr, lfsr_en);
      else passes++;
      repeat (3) tk();
      checks++;
      if (state_dbg !== ST_IDLE || lfsr_en !== 1'b0 || reaction_time !== last_res)
         $display("FAIL fs_no_game got state=%0d lfsr=%b time=%0d required %0d/0/%0d",
                  state_dbg, lfsr_en, reaction_time, ST_IDLE, last_res);
      else passes++;
   endtask

   task automatic test_timeout();
      play_round($urandom_range(1, 5), 255, 1'b0);
      repeat (4) tk();
      checks++;
      if (timeout !== 1'b1 || reaction_time !== 8'hFF)
         $display("FAIL timeout_hold got %b/%0d required 1/255", timeout, reaction_time);
      else passes++;
      play_round(2, 3, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 5; r++)
         play_round($urandom_range(0, 12), $urandom_range(0, 40), 1'(($urandom_range(0, 1))));
   endtask

   task automatic test_reset_mid_delay();
      start_game();
      countdown(20);
      repeat (2) tk();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({lfsr_en, ledr, reaction_time, result_valid, false_start, timeout} !== '0)
         $display("FAIL async_reset got %b required 0",
                  {lfsr_en, ledr, reaction_time, result_valid, false_start, timeout});
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      last_res = '0;
      repeat (3) tk();
      checks++;
      if (state_dbg !== ST_IDLE || ledr !== '0 || reaction_time !== '0)
         $display("FAIL reset_release got state=%0d ledr=%b time=%0d required %0d/0000/0",
                  state_dbg, ledr, reaction_time, ST_IDLE);
      else passes++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      play_round(3, 7, 1'b0);        // normal round
      play_round(0, $urandom_range(0, 20), 1'b0);  // zero delay
      test_false_start(1'b0);
      test_false_start(1'b1);
      test_timeout();
      play_round(4, 5, 1'b1);        // press coincides with a RUN tick
      test_random();
      test_reset_mid_delay();
      repeat (3) cyc(1'b0, 1'b1);
      checks++;
      if (rv_seen != n_exp || exp_q.size() != 0)
         $display("FAIL result_count got %0d required %0d", rv_seen, n_exp);
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
